mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits.
REQ-003 Parameter MAXBURST, default 4, maximum consecutive locked grants to port 1 while port 0 waits; legal range 1..15.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req0  input  1  port 0 (multicycle MIPS core) access request.
REQ-007 we0  input  1  port 0 write enable; 0 = read.
REQ-008 addr0  input  AW  port 0 address.
REQ-009 wdata0  input  DW  port 0 write data.
REQ-010 ack0  output  1  port 0 transaction complete, one-cycle pulse.
REQ-011 req1, we1, addr1, wdata1, ack1: same widths and meanings for port 1 (DMA/loader).
REQ-012 lock1  input  1  port 1 burst lock request.
REQ-013 rdata  output  DW  read data, shared by both ports.
REQ-014 mem_en  output  1  memory access strobe.
REQ-015 mem_we  output  1  memory write enable.
REQ-016 mem_addr  output  AW, mem_wdata  output  DW  memory address and write data.
REQ-017 mem_rdata  input  DW  synchronous-RAM read data, valid the cycle after mem_en.
REQ-018 owner  output  1  port holding the current or most recent grant.
REQ-019 busy  output  1  high in ACC and RESP states.

Function
REQ-020 FSM states SHALL be IDLE, ACC, RESP; owner register selects the granted port.
REQ-021 Arbitration points: IDLE, and RESP (back-to-back). If no req is high, next state is IDLE; otherwise next state is ACC with owner updated per REQ-022..024.
REQ-022 One request only: grant that port.
REQ-023 Both requests: round-robin, grant the port not equal to owner, except under REQ-024.
REQ-024 Locked burst: owner==1, lock1=1, req1=1 and burst_cnt<MAXBURST: grant port 1 even when req0=1.
REQ-025 burst_cnt (4 bits): cleared on any grant to port 0 or on any arbitration point with lock1=0; incremented on each port 1 grant taken with lock1=1; saturates at MAXBURST.
REQ-026 ACC: mem_en=1, mem_we/mem_addr/mem_wdata taken combinationally from the owner port's we/addr/wdata; next state RESP unconditionally.
REQ-027 RESP: ack of the owner port =1 for exactly this cycle; rdata=mem_rdata if owner's we=0, else 0.
REQ-028 Outside ACC: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. Outside RESP: ack0=ack1=0, rdata=0.
REQ-029 Latency: req seen in IDLE at cycle T gives ACC at T+1 and ack at T+2; back-to-back throughput is one access per 2 cycles.
REQ-030 Requester SHALL hold req, we, addr and wdata stable from assertion through its ack cycle; a req deasserted before ack is a protocol violation (behaviour undefined, no assertion required).
REQ-031 A requester keeping req high during its ack cycle is treated as a new request at that RESP arbitration point.
REQ-032 ack0 and ack1 SHALL never be high simultaneously; mem_en SHALL never be high in two consecutive cycles.
REQ-033 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-034 reset=0 SHALL immediately force state=IDLE, owner=1, burst_cnt=0, and all outputs to 0, including mid-transaction in ACC or RESP (access dropped, no ack).
REQ-035 After reset release, the first tie between req0 and req1 SHALL be granted to port 0.

Verification
REQ-036 Single read: req0=1, we0=0, addr0=0x40, mem_rdata=0xDEADBEEF in RESP -> mem_en at T+1 with mem_addr=0x40; ack0 and rdata=0xDEADBEEF at T+2.
REQ-037 Tie after reset: req0=req1=1, both held -> grant order 0,1,0,1; acks at T+2, T+4, T+6, T+8.
REQ-038 Locked burst: MAXBURST=4, req0=req1=lock1=1, owner=1 at start -> after the first port 0 grant, 4 consecutive port 1 acks, then 1 port 0 ack, repeating.
REQ-039 Write: req1=1, we1=1, addr1=0x10, wdata1=0x12345678 -> ACC cycle shows mem_we=1, mem_addr=0x10, mem_wdata=0x12345678; ack1 next cycle with rdata=0.
REQ-040 Reset mid-ACC: reset=0 asserted while in ACC -> mem_en drops to 0 without a clock edge; no ack; IDLE after release.
REQ-041 Idle gap: req deasserted in ack cycle -> IDLE next cycle, busy=0, mem_en=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin memory arbiter with port 1 locked bursts
module mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAXBURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    input  logic          lock1,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] MAXB = 4'(MAXBURST);

    state_t     state, state_nxt;
    logic       owner_q, owner_nxt;
    logic [3:0] burst_cnt, burst_nxt;
    // Owner resets to 1 so that round-robin hands the first tie to port 0;
    // granted_q keeps that fictitious ownership from starting a locked burst.
    logic       granted_q, granted_nxt;
    logic       gnt;

    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    assign sel_we    = owner_q ? we1    : we0;
    assign sel_addr  = owner_q ? addr1  : addr0;
    assign sel_wdata = owner_q ? wdata1 : wdata0;
    assign owner     = owner_q;

    // State, owner and burst counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner_q   <= 1'b1;
            burst_cnt <= 4'd0;
            granted_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner_q   <= owner_nxt;
            burst_cnt <= burst_nxt;
            granted_q <= granted_nxt;
        end
    end

    // Next state and arbitration decision at IDLE and RESP
    always_comb begin
        state_nxt   = IDLE;
        owner_nxt   = owner_q;
        burst_nxt   = burst_cnt;
        granted_nxt = granted_q;
        gnt         = owner_q;
        case (state)
            ACC: state_nxt = RESP;
            IDLE, RESP: begin
                if (!lock1) begin
                    burst_nxt = 4'd0;
                end
                if (req0 || req1) begin
                    state_nxt = ACC;
                    if (req0 && req1) begin
                        if (granted_q && owner_q && lock1 && (burst_cnt < MAXB)) begin
                            gnt = 1'b1;
                        end else begin
                            gnt = ~owner_q;
                        end
                    end else begin
                        gnt = req1;
                    end
                    owner_nxt   = gnt;
                    granted_nxt = 1'b1;
                    if (!gnt) begin
                        burst_nxt = 4'd0;
                    end else if (lock1 && (burst_cnt < MAXB)) begin
                        burst_nxt = burst_cnt + 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory strobe, acks and read data decoded from state and owner
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        rdata     = '0;
        busy      = 1'b0;
        case (state)
            ACC: begin
                busy      = 1'b1;
                mem_en    = 1'b1;
                mem_we    = sel_we;
                mem_addr  = sel_addr;
                mem_wdata = sel_wdata;
            end
            RESP: begin
                busy = 1'b1;
                ack0 = ~owner_q;
                ack1 = owner_q;
                if (!sel_we) begin
                    rdata = mem_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed bench for mem_arbiter against a behavioural model
module tb_mem_arbiter;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1, lock1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, mem_en, mem_we, owner, busy;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic        rq  [2];
    logic        rwe [2];
    logic [31:0] raddr [2];
    logic [31:0] rwd [2];

    assign req0   = rq[0];
    assign req1   = rq[1];
    assign we0    = rwe[0];
    assign we1    = rwe[1];
    assign addr0  = raddr[0];
    assign addr1  = raddr[1];
    assign wdata0 = rwd[0];
    assign wdata1 = rwd[1];

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32), .MAXBURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .lock1(lock1), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: phase of the current transaction (0 none, 1 memory access, 2 response)
    int m_st;
    int m_owner;
    int m_burst;
    bit m_fresh;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st    = 0;
        m_owner = 1;
        m_burst = 0;
        m_fresh = 1'b1;
    endtask

    task automatic model_step();
        int g;
        if (!reset) begin
            model_reset();
            return;
        end
        if (m_st == 1) begin
            m_st = 2;
            return;
        end
        if (!req0 && !req1) begin
            if (!lock1) m_burst = 0;
            m_st = 0;
            return;
        end
        if (req0 && req1) begin
            if (!m_fresh && m_owner == 1 && lock1 && m_burst < MAXB) g = 1;
            else g = 1 - m_owner;
        end else begin
            g = req1 ? 1 : 0;
        end
        if (g == 0 || !lock1) m_burst = 0;
        else if (m_burst < MAXB) m_burst = m_burst + 1;
        m_owner = g;
        m_fresh = 1'b0;
        m_st    = 1;
    endtask

    task automatic check_outputs();
        logic        o_we;
        logic [31:0] o_addr, o_wd;
        o_we   = (m_owner == 1) ? we1 : we0;
        o_addr = (m_owner == 1) ? addr1 : addr0;
        o_wd   = (m_owner == 1) ? wdata1 : wdata0;
        chk("mem_en",    mem_en,    m_st == 1);
        chk("mem_we",    mem_we,    (m_st == 1) && o_we);
        chk("mem_addr",  mem_addr,  (m_st == 1) ? o_addr : 32'd0);
        chk("mem_wdata", mem_wdata, (m_st == 1) ? o_wd : 32'd0);
        chk("ack0",      ack0,      (m_st == 2) && (m_owner == 0));
        chk("ack1",      ack1,      (m_st == 2) && (m_owner == 1));
        chk("rdata",     rdata,     ((m_st == 2) && !o_we) ? mem_rdata : 32'd0);
        chk("busy",      busy,      m_st != 0);
        chk("owner",     owner,     m_owner[0]);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic advance();
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        model_reset();
        repeat (cycles) step();
        reset = 1'b1;
    endtask

    task automatic drive_random();
        for (int p = 0; p < 2; p++) begin
            if (m_st == 2 && m_owner == p) begin
                if (rq[p]) rq[p] = ($urandom_range(0, 2) != 0);
            end else if (!rq[p] && $urandom_range(0, 3) == 0) begin
                rq[p]    = 1'b1;
                rwe[p]   = 1'($urandom_range(0, 1));
                raddr[p] = $urandom;
                rwd[p]   = $urandom;
            end
        end
        if ($urandom_range(0, 9) == 0) lock1 = ($urandom_range(0, 2) != 0);
        mem_rdata = $urandom;
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            rq[p] = 1'b0; rwe[p] = 1'b0; raddr[p] = '0; rwd[p] = '0;
        end
        lock1     = 1'b0;
        mem_rdata = 32'h0;
        reset     = 1'b0;
        model_reset();

        // Reset state
        settle();
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_owner", owner, 1'b1);
        advance();
        step();
        reset = 1'b1;

        // Single read on port 0
        rq[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 32'h40;
        step();
        settle();
        chk("rd_mem_en", mem_en, 1'b1);
        chk("rd_mem_addr", mem_addr, 32'h40);
        advance();
        rq[0] = 1'b0; mem_rdata = 32'hDEADBEEF;
        settle();
        chk("rd_ack0", ack0, 1'b1);
        chk("rd_rdata", rdata, 32'hDEADBEEF);
        advance();
        settle();
        chk("gap_busy", busy, 1'b0);
        chk("gap_mem_en", mem_en, 1'b0);
        advance();

        // Write on port 1
        rq[1] = 1'b1; rwe[1] = 1'b1; raddr[1] = 32'h10; rwd[1] = 32'h12345678;
        step();
        settle();
        chk("wr_mem_we", mem_we, 1'b1);
        chk("wr_mem_addr", mem_addr, 32'h10);
        chk("wr_mem_wdata", mem_wdata, 32'h12345678);
        advance();
        rq[1] = 1'b0; mem_rdata = 32'hFFFFFFFF;
        settle();
        chk("wr_ack1", ack1, 1'b1);
        chk("wr_rdata", rdata, 32'h0);
        advance();
        step();

        // Tie after reset: grants alternate starting with port 0
        do_reset(2);
        rq[0] = 1'b1; rwe[0] = 1'b0; rq[1] = 1'b1; rwe[1] = 1'b0; lock1 = 1'b0;
        step();
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) begin rq[0] = 1'b0; rq[1] = 1'b0; end
            settle();
            if (k % 2 == 0) begin
                chk("tie_ack0", ack0, (k % 4) == 2);
                chk("tie_ack1", ack1, (k % 4) == 0);
            end
            advance();
        end
        step();

        // Locked burst: port 0, then MAXB port 1 grants, repeating
        do_reset(2);
        rq[0] = 1'b1; rq[1] = 1'b1; lock1 = 1'b1;
        step();
        for (int k = 1; k <= 20; k++) begin
            if (k == 20) begin rq[0] = 1'b0; rq[1] = 1'b0; end
            settle();
            if (k % 2 == 0) begin
                chk("burst_ack1", ack1, ((k / 2 - 1) % (MAXB + 1)) != 0);
                chk("burst_ack0", ack0, ((k / 2 - 1) % (MAXB + 1)) == 0);
            end
            advance();
        end
        lock1 = 1'b0;
        step();

        // Reset asserted during the access cycle
        rq[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 32'h80;
        step();
        #2;
        chk("racc_mem_en_before", mem_en, 1'b1);
        reset = 1'b0;
        model_reset();
        #1;
        chk("racc_mem_en", mem_en, 1'b0);
        chk("racc_busy", busy, 1'b0);
        chk("racc_ack0", ack0, 1'b0);
        rq[0] = 1'b0;
        step();
        step();
        reset = 1'b1;
        settle();
        chk("racc_idle_busy", busy, 1'b0);
        advance();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            if ($urandom_range(0, 399) == 0) begin
                do_reset(1);
            end else begin
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
